// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA copper sequencer.
//   - copper FSM state encoding
//   - display-list entry field positions and field extraction helpers
//   - VGA peripheral register addresses (0x30..0x3C)
//   - peripheral write-size encodings
package vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } copper_state_e;

  // Display-list entry layout
  localparam int ENT_EOL_BIT    = 31;
  localparam int ENT_IRQ_BIT    = 30;
  localparam int ENT_WAIT_Y_MSB = 25;
  localparam int ENT_WAIT_Y_LSB = 16;
  localparam int ENT_ADDR_MSB   = 13;
  localparam int ENT_ADDR_LSB   = 8;
  localparam int ENT_VALUE_MSB  = 7;
  localparam int ENT_VALUE_LSB  = 0;

  // VGA peripheral register map
  localparam logic [5:0] REG_BG_COLOUR = 6'h30;
  localparam logic [5:0] REG_FG_COLOUR = 6'h31;
  localparam logic [5:0] REG_F2_COLOUR = 6'h32;
  localparam logic [5:0] REG_F3_COLOUR = 6'h33;
  localparam logic [5:0] REG_STRIDE    = 6'h34;
  localparam logic [5:0] REG_PIX_SIZE  = 6'h38;
  localparam logic [5:0] REG_MODE      = 6'h3C;

  // Bus write-size encodings
  localparam logic [1:0] WRITE_NONE = 2'b11;
  localparam logic [1:0] WRITE_BYTE = 2'b00;

  function automatic logic [9:0] entry_wait_y(input logic [31:0] entry);
    return entry[ENT_WAIT_Y_MSB:ENT_WAIT_Y_LSB];
  endfunction

  function automatic logic [5:0] entry_addr(input logic [31:0] entry);
    return entry[ENT_ADDR_MSB:ENT_ADDR_LSB];
  endfunction

  function automatic logic [7:0] entry_value(input logic [31:0] entry);
    return entry[ENT_VALUE_MSB:ENT_VALUE_LSB];
  endfunction

endpackage

// File: rtl/vga_copper_list.sv
// vga_copper_list: DEPTH x 32 display-list storage.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  single write port, written on the clock edge
//   re, raddr         registered read: rdata loads mem[raddr] when re is high
//   rdata             last fetched entry, stable until the next re
// The array itself is not reset; its contents survive rst_n.
module vga_copper_list #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Entry storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Fetch register: holds the command being waited on / issued, so a
  // concurrent reprogram of the same slot cannot disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_copper_sequencer.sv
// vga_copper_sequencer: scanline-synchronous register sequencer ("copper")
// between the TinyQV bus and the VGA peripheral register write port.
// Replays a display list of (wait_y, reg, value) commands once per frame;
// CPU writes pass through combinationally and always win the port.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   enable                           run the list each frame when high
//   vga_y, vga_frame_start           scanline and frame-start pulse
//   prog_we, prog_addr, prog_data    display-list programming port
//   cpu_address/data_in/write_n      CPU write request (write_n 11 = none)
//   per_address/data/write_n         muxed write port to the VGA peripheral
//   busy                             list in progress (FETCH/WAIT/ISSUE)
//   copper_irq                       1-cycle pulse after an issued irq entry
// Optional build macro: COPPER_IRQ_EN enables copper_irq generation; when
// undefined copper_irq is tied low and entry bit 30 is ignored.
module vga_copper_sequencer
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [9:0]    vga_y,
  input  logic          vga_frame_start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic [5:0]    cpu_address,
  input  logic [31:0]   cpu_data_in,
  input  logic [1:0]    cpu_write_n,
  output logic [5:0]    per_address,
  output logic [31:0]   per_data,
  output logic [1:0]    per_write_n,
  output logic          busy,
  output logic          copper_irq
);

  copper_state_e state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [31:0]   cmd_s;
  logic          cpu_idle_s;
  logic          reached_s;
  logic          last_s;
  logic          issue_s;

  vga_copper_list #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_list (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (prog_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .re   (state_q == ST_FETCH),
    .raddr(index_q),
    .rdata(cmd_s)
  );

  assign cpu_idle_s = (cpu_write_n == WRITE_NONE);
  assign reached_s  = (vga_y >= entry_wait_y(cmd_s));
  assign last_s     = cmd_s[ENT_EOL_BIT] || (index_q == AW'(DEPTH - 1));
  // A pending copper write is dropped on frame abort or disable
  assign issue_s    = (state_q == ST_ISSUE) && cpu_idle_s && enable && !vga_frame_start;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_ISSUE);

  // FSM state and list index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Next-state logic: disable beats frame start, frame start restarts the
  // list from any state (IDLE/DONE start, otherwise overrun abort)
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (vga_frame_start) begin
      state_d = ST_FETCH;
      index_d = {AW{1'b0}};
    end else begin
      case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          if (reached_s) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_ISSUE: begin
          if (!cpu_idle_s) begin
            state_d = ST_ISSUE;
          end else if (last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            index_d = index_q + AW'(1);
          end
        end
        ST_IDLE, ST_DONE: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Peripheral port mux: CPU has priority, copper fills idle cycles,
  // outputs held at their reset values while rst_n is low
  always_comb begin
    per_address = cpu_address;
    per_data    = cpu_data_in;
    per_write_n = cpu_write_n;
    if (!rst_n) begin
      per_address = 6'd0;
      per_data    = 32'd0;
      per_write_n = WRITE_NONE;
    end else if (issue_s) begin
      per_address = entry_addr(cmd_s);
      per_data    = {24'd0, entry_value(cmd_s)};
      per_write_n = WRITE_BYTE;
    end else begin
      per_address = cpu_address;
      per_data    = cpu_data_in;
      per_write_n = cpu_write_n;
    end
  end

`ifdef COPPER_IRQ_EN
  logic irq_q, irq_d;
  logic unused_cmd_bits_s;

  assign irq_d             = issue_s && cmd_s[ENT_IRQ_BIT];
  assign unused_cmd_bits_s = ^{cmd_s[29:26], cmd_s[15:14]};

  // Interrupt pulse, one cycle after the write actually went out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign copper_irq = irq_q;
`else
  logic unused_cmd_bits_s;

  assign unused_cmd_bits_s = ^{cmd_s[30:26], cmd_s[15:14]};
  assign copper_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_copper_sequencer.sv
module tb_vga_copper_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [9:0]    vga_y;
  logic          vga_frame_start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [5:0]    cpu_address;
  logic [31:0]   cpu_data_in;
  logic [1:0]    cpu_write_n;
  logic [5:0]    per_address;
  logic [31:0]   per_data;
  logic [1:0]    per_write_n;
  logic          busy;
  logic          copper_irq;

  vga_copper_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .vga_y          (vga_y),
    .vga_frame_start(vga_frame_start),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .cpu_address    (cpu_address),
    .cpu_data_in    (cpu_data_in),
    .cpu_write_n    (cpu_write_n),
    .per_address    (per_address),
    .per_data       (per_data),
    .per_write_n    (per_write_n),
    .busy           (busy),
    .copper_irq     (copper_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  wn;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn, input int at);
    exp_t e;
    e.addr = a; e.data = d; e.wn = wn; e.at = at;
    sb_q.push_back(e);
  endtask

  task automatic prog(input int idx, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(idx);
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse(output int p);
    vga_frame_start = 1'b1;
    p = cyc;
    tick();
    vga_frame_start = 1'b0;
  endtask

  // Scoreboard monitor: every write seen on the peripheral port pops one expectation
  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (per_write_n !== 2'b11) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got addr %h data %h wn %b at cycle %0d, expected no write",
                   per_address, per_data, per_write_n, cyc);
        end else begin
          e = sb_q.pop_front();
          if (per_address !== e.addr || per_data !== e.data || per_write_n !== e.wn || cyc != e.at) begin
            errors++;
            $display("FAIL sb_write: got addr %h data %h wn %b cycle %0d, expected addr %h data %h wn %b cycle %0d",
                     per_address, per_data, per_write_n, cyc, e.addr, e.data, e.wn, e.at);
          end
        end
      end
    end
  endtask

  initial begin
    int p;
    int q;
    logic irq_exp;

    rst_n = 1'b0; enable = 1'b0; vga_y = 10'd0; vga_frame_start = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = 32'd0;
    cpu_address = 6'd0; cpu_data_in = 32'd0; cpu_write_n = 2'b11;
    fork
      run_monitor();
    join_none

    // Reset state
    repeat (3) tick();
    check("reset_wn", 32'(per_write_n), 32'h3);
    check("reset_addr", 32'(per_address), 32'h0);
    check("reset_data", per_data, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_irq", 32'(copper_irq), 32'h0);
    rst_n = 1'b1;
    tick();

    // Test 1: single eol entry wait_y=100 -> one write once vga_y reaches 100
    prog(0, 32'h8064_3015);
    enable = 1'b1; vga_y = 10'd99;
    pulse(p);
    repeat (5) tick();
    check("t1_busy_wait", 32'(busy), 32'h1);
    vga_y = 10'd100; q = cyc;
    push(6'h30, 32'h0000_0015, 2'b00, q + 1);
    repeat (3) tick();
    check("t1_busy_done", 32'(busy), 32'h0);
    repeat (10) tick();

    // Test 2: wait_y 10,10,20 then no eol -> runs to DEPTH-1
    prog(0, 32'h000A_3101);
    prog(1, 32'h000A_3202);
    prog(2, 32'h0014_3303);
    for (int k = 3; k < DEPTH; k++) prog(k, 32'h0000_3400 | 32'(k));
    vga_y = 10'd15;
    pulse(p);
    push(6'h31, 32'h0000_0001, 2'b00, p + 3);
    push(6'h32, 32'h0000_0002, 2'b00, p + 6);
    repeat (11) tick();
    vga_y = 10'd20; q = cyc;
    push(6'h33, 32'h0000_0003, 2'b00, q + 1);
    for (int k = 3; k < DEPTH; k++) push(6'h34, 32'(k), 2'b00, q + 1 + 3 * (k - 2));
    repeat (45) tick();
    check("t2_busy_done", 32'(busy), 32'h0);

    // Test 3: 5-cycle CPU write collides with the copper ISSUE cycle
    prog(0, 32'h8000_3C5A);
    vga_y = 10'd0;
    pulse(p);
    for (int i = 0; i < 5; i++) push(6'h10 + 6'(i), 32'hC0DE_0000 + 32'(i), 2'b10, p + 3 + i);
    push(6'h3C, 32'h0000_005A, 2'b00, p + 8);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      cpu_address = 6'h10 + 6'(i);
      cpu_data_in = 32'hC0DE_0000 + 32'(i);
      cpu_write_n = 2'b10;
      tick();
    end
    cpu_write_n = 2'b11;
    repeat (5) tick();

    // Test 4: frame pulse while waiting on entry 3 (wait_y 900) restarts the list
    prog(0, 32'h0000_30A0);
    prog(1, 32'h0000_30A1);
    prog(2, 32'h0000_30A2);
    prog(3, 32'h8384_30A3);
    vga_y = 10'd5;
    pulse(p);
    push(6'h30, 32'h0000_00A0, 2'b00, p + 3);
    push(6'h30, 32'h0000_00A1, 2'b00, p + 6);
    push(6'h30, 32'h0000_00A2, 2'b00, p + 9);
    repeat (14) tick();
    check("t4_busy_stuck", 32'(busy), 32'h1);
    pulse(p);
    push(6'h30, 32'h0000_00A0, 2'b00, p + 3);
    push(6'h30, 32'h0000_00A1, 2'b00, p + 6);
    push(6'h30, 32'h0000_00A2, 2'b00, p + 9);
    repeat (12) tick();
    enable = 1'b0;
    repeat (2) tick();
    check("t4_disable_idle", 32'(busy), 32'h0);

    // Test 5: asynchronous reset in the ISSUE cycle
    prog(0, 32'h8000_3B77);
    enable = 1'b1;
    pulse(p);
    repeat (2) tick();
    check("t5_issue_wn", 32'(per_write_n), 32'h0);
    check("t5_issue_addr", 32'(per_address), 32'h3B);
    rst_n = 1'b0;
    #1;
    check("t5_rst_wn", 32'(per_write_n), 32'h3);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_addr", 32'(per_address), 32'h0);
    check("t5_rst_data", per_data, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t5_idle_after_rst", 32'(busy), 32'h0);
    pulse(p);
    push(6'h3B, 32'h0000_0077, 2'b00, p + 3);
    repeat (6) tick();

    // Test 6: irq entry after a 2-cycle CPU collision
    prog(0, 32'hC000_3142);
    pulse(p);
    push(6'h20, 32'hBEEF_0000, 2'b01, p + 3);
    push(6'h21, 32'hBEEF_0001, 2'b01, p + 4);
    push(6'h31, 32'h0000_0042, 2'b00, p + 5);
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      cpu_address = 6'h20 + 6'(i);
      cpu_data_in = 32'hBEEF_0000 + 32'(i);
      cpu_write_n = 2'b01;
      tick();
    end
    cpu_write_n = 2'b11;
    for (int j = 0; j < 4; j++) begin
`ifdef COPPER_IRQ_EN
      irq_exp = (cyc == p + 6);
`else
      irq_exp = 1'b0;
`endif
      check("t6_irq", 32'(copper_irq), 32'(irq_exp));
      tick();
    end

    repeat (5) tick();
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
